axi4m_read_scheduler: RTL and testbench
=======================================

# axi4m_read_scheduler

Round-robin scheduler that shares a single AXI4 read-to-FIFO master between `NUM_REQ` requesters. It validates each request, drives the master's kick/num/addr job interface and waits for the job to complete. It steers the master's FIFO write stream to the owning requester and signals per-requester completion with a beat-count check. It sits between client DMA engines and the AXI4 read master.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_WIDTH`, 32: width of the FIFO write data.
- `MAX_BEATS`, 16320: largest legal job, in beats. This is 255 bursts of 64 beats, the limit of the master's 8-bit burst counter.
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: request pending, one bit per requester.
- `req_num` in 32*NUM_REQ: beat count; slice i belongs to requester i.
- `req_addr` in 32*NUM_REQ: byte start address; slice i belongs to requester i.
- `req_ready` out NUM_REQ: one-cycle accept pulse to the granted requester.
- `done` out NUM_REQ: one-cycle completion pulse.
- `err` out NUM_REQ: asserted together with `done` when the job was rejected or its beat count mismatched.
- `rd_kick` out 1: one-cycle start pulse to the master.
- `rd_num` out 32: job length driven to the master.
- `rd_addr` out 32: job address driven to the master.
- `rd_busy` in 1: master busy.
- `buf_we` in 1: master FIFO write strobe.
- `buf_dout` in DATA_WIDTH: master FIFO write data.
- `out_we` out NUM_REQ: `buf_we` gated to the current owner.
- `out_dout` out DATA_WIDTH: `buf_dout`, broadcast to all requesters.
- `owner` out $clog2(NUM_REQ): index of the current owner.
- `owner_valid` out 1: an owner is present.

## Operation
- States:
  - `S_IDLE`: select a winner.
  - `S_CHECK`: validate the captured request.
  - `S_KICK`: start the master.
  - `S_WAITBUSY`: wait for the master to go busy.
  - `S_RUN`: wait for the master to go idle.
  - `S_DONE`: signal completion.
- `S_IDLE`, when any `req_valid` is set:
  - Pick the first set bit at or after `rr_ptr`, wrapping around.
  - Pulse `req_ready[winner]`, capture `num`/`addr`, set `owner`.
  - Set `rr_ptr` to winner+1 mod NUM_REQ.
  - Go to `S_CHECK`.
- `S_CHECK`:
  - If `num==0` or `num>MAX_BEATS`, go to `S_DONE` with the error flag set. No kick is issued; the master misbehaves on `num==0`.
  - Otherwise go to `S_KICK`.
- `S_KICK`: assert `rd_kick` for exactly one cycle, then go to `S_WAITBUSY`.
- `S_WAITBUSY`: when `rd_busy==1`, go to `S_RUN`.
- `S_RUN`: when `rd_busy==0`, go to `S_DONE`.
- `S_DONE`:
  - Pulse `done[owner]`.
  - Drive `err[owner]` as error flag OR (`beat_cnt != num`).
  - Clear `owner_valid`, return to `S_IDLE`.
- `beat_cnt`:
  - 32-bit counter, cleared on accept.
  - Increments on each `buf_we` while `owner_valid`.
- `buf_we` arriving while `owner_valid==0` is dropped. It never appears on any `out_we` bit.
- `rd_num` and `rd_addr` hold the captured values from `S_KICK` until the next accept.
- A requester must hold `req_valid`, `req_num` and `req_addr` stable until it sees `req_ready`. Deasserting `req_valid` early is legal; that requester simply loses arbitration.

## Timing
- Reset values: all outputs 0, `rr_ptr`=0, state `S_IDLE`.
- `reset_n` low mid-job returns the block to `S_IDLE` immediately. No `done` pulse is produced; the master must be reset by the same reset.
- Latency:
  - Accept, then `rd_kick` 2 cycles later.
  - `rd_busy` falling, then `done` on the following cycle.
  - Invalid request: accept, then `done`/`err` 2 cycles later.
- `out_we` and `out_dout` are combinational from `buf_we` and `buf_dout`, so there is zero added latency.
- `owner_valid` is 1 from the cycle after accept through the `S_DONE` cycle. The master's last `buf_we` precedes its `rd_busy` fall, so it is always counted.
- Consecutive jobs need at least 1 idle cycle between `done` and the next accept.
- Simultaneous requests are resolved by round-robin only. A single requester holding `req_valid` continuously is re-granted every job.

## Structure
- Shared package `axi4m_sched_pkg`:
  - State enum.
  - `MAX_BURST_LENGTH`=64.
  - Derived `MAX_BEATS`.
- One sub-module, `rr_arbiter`: inputs `req`[NUM_REQ] and `ptr`; outputs one-hot `gnt` and index `gnt_idx`; purely combinational.
- The FSM, capture registers, beat counter and steering logic live in the top module.

## Test plan
- Single job: requester 0, `num`=100, `addr`=0x1000, master model returns 100 beats.
  - Response: `rd_kick` once with `rd_num`=100 and `rd_addr`=0x1000.
  - `out_we[0]` pulses 100 times and no other `out_we` bit toggles.
  - `done[0]`=1 and `err[0]`=0.
- All 4 requesters valid at once, each with `num`=8.
  - Grants follow 0,1,2,3.
  - Requester 1 then re-requests; it is granted after 3, not before.
- `num`=0 on requester 2: `done[2]` and `err[2]` pulse 2 cycles after accept, with no `rd_kick`.
- `num`=16321: rejected with `err`. `num`=16320: accepted and kicked.
- Master model delivers 63 beats for `num`=64: `done` with `err`=1.
- `reset_n` low during `S_RUN`:
  - All outputs return to 0 and `rr_ptr`=0.
  - After release, a new request is accepted normally.

Source files
------------

// File: rtl/axi4m_read_scheduler_pkg.sv
// Shared types and limits for the AXI4 read scheduler: FSM states and the
// largest job the read master's 8-bit burst counter can express.
package axi4m_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CHECK    = 3'd1,
        S_KICK     = 3'd2,
        S_WAITBUSY = 3'd3,
        S_RUN      = 3'd4,
        S_DONE     = 3'd5
    } sched_state_e;

    localparam int MAX_BURST_LENGTH = 64;
    localparam int MAX_BURSTS       = 255;
    localparam int MAX_BEATS        = MAX_BURSTS * MAX_BURST_LENGTH;

    // The master misbehaves on a zero-length job, so zero is rejected too.
    function automatic logic job_len_ok(input logic [31:0] num, input logic [31:0] max_beats);
        return (num != 32'd0) && (num <= max_beats);
    endfunction

endpackage

// File: rtl/axi4m_read_scheduler_if.sv
// Bundle of requester-side, master-job and FIFO-steering signals of the scheduler.
// The master modport is the scheduler's view; slave is the surrounding system.
interface axi4m_read_scheduler_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [32*NUM_REQ-1:0]      req_num;
    logic [32*NUM_REQ-1:0]      req_addr;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         done;
    logic [NUM_REQ-1:0]         err;
    logic                       rd_kick;
    logic [31:0]                rd_num;
    logic [31:0]                rd_addr;
    logic                       rd_busy;
    logic                       buf_we;
    logic [DATA_WIDTH-1:0]      buf_dout;
    logic [NUM_REQ-1:0]         out_we;
    logic [DATA_WIDTH-1:0]      out_dout;
    logic [$clog2(NUM_REQ)-1:0] owner;
    logic                       owner_valid;

    modport master (
        input  req_valid, req_num, req_addr, rd_busy, buf_we, buf_dout,
        output req_ready, done, err, rd_kick, rd_num, rd_addr,
        output out_we, out_dout, owner, owner_valid
    );

    modport slave (
        output req_valid, req_num, req_addr, rd_busy, buf_we, buf_dout,
        input  req_ready, done, err, rd_kick, rd_num, rd_addr,
        input  out_we, out_dout, owner, owner_valid
    );
endinterface

// File: rtl/axi4m_read_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);
    logic [IDX_W-1:0] cand_s;
    logic             found_s;

    // Scan candidates in priority order starting at ptr.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found_s && req[cand_s]) begin
                found_s      = 1'b1;
                gnt[cand_s]  = 1'b1;
                gnt_idx      = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end
endmodule

// File: rtl/axi4m_read_scheduler.sv
// Shares one AXI4 read-to-FIFO master among NUM_REQ requesters: round-robin
// accept, length check, kick/wait of the master, FIFO steering, done/err report.
module axi4m_read_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = axi4m_sched_pkg::MAX_BEATS
) (
    input  logic clk,
    input  logic reset_n,
    axi4m_read_scheduler_if.master bus
);
    import axi4m_sched_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    sched_state_e          state_r;
    logic [NUM_REQ-1:0]    gnt_s;
    logic [IDX_W-1:0]      gnt_idx_s;
    logic [IDX_W-1:0]      rr_ptr_r;
    logic [IDX_W-1:0]      owner_r;
    logic                  owner_valid_r;
    logic [NUM_REQ-1:0]    owner_oh_s;
    logic [31:0]           num_r;
    logic [31:0]           addr_r;
    logic [31:0]           beat_cnt_r;
    logic [31:0]           rd_num_r;
    logic [31:0]           rd_addr_r;
    logic                  rd_kick_r;
    logic [NUM_REQ-1:0]    done_r;
    logic [NUM_REQ-1:0]    err_r;
    logic [DATA_WIDTH-1:0] dout_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (bus.req_valid),
        .ptr     (rr_ptr_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    assign owner_oh_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_r;

    // Accept and FIFO steering are zero-latency; the arbiter only acts in idle.
    assign bus.req_ready   = (state_r == S_IDLE) ? gnt_s : {NUM_REQ{1'b0}};
    assign bus.out_we      = (owner_valid_r && bus.buf_we) ? owner_oh_s : {NUM_REQ{1'b0}};
    assign dout_s          = bus.buf_dout;
    assign bus.out_dout    = dout_s;
    assign bus.done        = done_r;
    assign bus.err         = err_r;
    assign bus.rd_kick     = rd_kick_r;
    assign bus.rd_num      = rd_num_r;
    assign bus.rd_addr     = rd_addr_r;
    assign bus.owner       = owner_r;
    assign bus.owner_valid = owner_valid_r;

    // Job FSM with registered pulse outputs, capture registers and beat counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= S_IDLE;
            rr_ptr_r      <= '0;
            owner_r       <= '0;
            owner_valid_r <= 1'b0;
            num_r         <= 32'd0;
            addr_r        <= 32'd0;
            beat_cnt_r    <= 32'd0;
            rd_num_r      <= 32'd0;
            rd_addr_r     <= 32'd0;
            rd_kick_r     <= 1'b0;
            done_r        <= '0;
            err_r         <= '0;
        end else begin
            rd_kick_r <= 1'b0;
            done_r    <= '0;
            err_r     <= '0;
            if (owner_valid_r && bus.buf_we) begin
                beat_cnt_r <= beat_cnt_r + 32'd1;
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
            case (state_r)
                S_IDLE: begin
                    if (|bus.req_valid) begin
                        owner_r       <= gnt_idx_s;
                        owner_valid_r <= 1'b1;
                        num_r         <= bus.req_num[{gnt_idx_s, 5'd0} +: 32];
                        addr_r        <= bus.req_addr[{gnt_idx_s, 5'd0} +: 32];
                        beat_cnt_r    <= 32'd0;
                        rr_ptr_r      <= (gnt_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_s + IDX_W'(1);
                        state_r       <= S_CHECK;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_CHECK: begin
                    if (job_len_ok(num_r, 32'(MAX_BEATS))) begin
                        rd_kick_r <= 1'b1;
                        rd_num_r  <= num_r;
                        rd_addr_r <= addr_r;
                        state_r   <= S_KICK;
                    end else begin
                        done_r  <= owner_oh_s;
                        err_r   <= owner_oh_s;
                        state_r <= S_DONE;
                    end
                end
                S_KICK: begin
                    state_r <= S_WAITBUSY;
                end
                S_WAITBUSY: begin
                    if (bus.rd_busy) begin
                        state_r <= S_RUN;
                    end else begin
                        state_r <= S_WAITBUSY;
                    end
                end
                S_RUN: begin
                    // Last FIFO write precedes the busy fall, so beat_cnt_r is final here.
                    if (!bus.rd_busy) begin
                        done_r  <= owner_oh_s;
                        err_r   <= (beat_cnt_r != num_r) ? owner_oh_s : {NUM_REQ{1'b0}};
                        state_r <= S_DONE;
                    end else begin
                        state_r <= S_RUN;
                    end
                end
                S_DONE: begin
                    owner_valid_r <= 1'b0;
                    state_r       <= S_IDLE;
                end
                default: begin
                    owner_valid_r <= 1'b0;
                    state_r       <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi4m_read_scheduler.sv
// Scoreboard bench for axi4m_read_scheduler with a behavioural read-master model.
module tb_axi4m_read_scheduler;

    typedef struct {
        int          idx;
        logic [31:0] num;
        logic [31:0] addr;
        int          kick;
        int          err;
        int          beats;
    } job_t;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_pass;
    int   grants_seen;
    int   short_by;
    job_t exp_q[$];

    axi4m_read_scheduler_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus ();

    axi4m_read_scheduler #(.NUM_REQ(4), .DATA_WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [3:0] oh(input int i);
        oh = 4'b0001 << i;
    endfunction

    task automatic submit(input int idx, input logic [31:0] num, input logic [31:0] addr,
                          input int kick, input int err, input int beats);
        job_t j;
        j.idx = idx; j.num = num; j.addr = addr; j.kick = kick; j.err = err; j.beats = beats;
        exp_q.push_back(j);
        bus.req_num[idx*32 +: 32]  = num;
        bus.req_addr[idx*32 +: 32] = addr;
        bus.req_valid[idx]         = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check_eq(tag, exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // Read-master model: goes busy after a kick and writes rd_num - short_by beats.
    initial begin
        int n;
        bus.rd_busy  = 1'b0;
        bus.buf_we   = 1'b0;
        bus.buf_dout = 32'd0;
        forever begin
            @(negedge clk);
            if (reset_n && bus.rd_kick) begin
                n = int'(bus.rd_num) - short_by;
                @(posedge clk); #1;
                bus.rd_busy = 1'b1;
                for (int b = 0; b < n && reset_n; b++) begin
                    bus.buf_we   = 1'b1;
                    bus.buf_dout = $urandom;
                    @(posedge clk); #1;
                end
                bus.buf_we  = 1'b0;
                bus.rd_busy = 1'b0;
            end
        end
    end

    // Requesters drop req_valid once they have seen their accept pulse.
    initial begin
        logic [3:0] g;
        forever begin
            @(negedge clk);
            g = bus.req_ready;
            @(posedge clk); #1;
            bus.req_valid = bus.req_valid & ~g;
        end
    end

    // Output monitor: grant order, kick contents/latency, done/err, steered beats.
    initial begin
        int   cyc, acc_cyc, fall_cyc, kick_cnt, other;
        int   we_cnt [4];
        logic prev_busy;
        job_t cur;
        cyc = 0; acc_cyc = 0; fall_cyc = 0; kick_cnt = 0; prev_busy = 1'b0;
        foreach (we_cnt[i]) we_cnt[i] = 0;
        cur.idx = 0; cur.num = 0; cur.addr = 0; cur.kick = 0; cur.err = 0; cur.beats = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                prev_busy = 1'b0;
                continue;
            end
            if (bus.req_ready != 4'd0) begin
                grants_seen++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_grant", bus.req_ready, 4'd0);
                end else begin
                    cur = exp_q[0];
                    check_eq("grant", bus.req_ready, oh(cur.idx));
                end
                acc_cyc = cyc; kick_cnt = 0; fall_cyc = -100;
                foreach (we_cnt[i]) we_cnt[i] = 0;
            end
            for (int i = 0; i < 4; i++) begin
                if (bus.out_we[i]) we_cnt[i]++;
            end
            if (bus.buf_we) check_eq("out_dout", bus.out_dout, bus.buf_dout);
            if (bus.rd_kick) begin
                kick_cnt++;
                check_eq("kick_lat", cyc - acc_cyc, 2);
                check_eq("rd_num", bus.rd_num, cur.num);
                check_eq("rd_addr", bus.rd_addr, cur.addr);
            end
            if (prev_busy && !bus.rd_busy) fall_cyc = cyc;
            prev_busy = bus.rd_busy;
            if ((bus.err & ~bus.done) != 4'd0) check_eq("err_wo_done", bus.err, bus.done);
            if (bus.done != 4'd0) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_done", bus.done, 4'd0);
                end else begin
                    check_eq("done_idx", bus.done, oh(cur.idx));
                    check_eq("err", bus.err, (cur.err != 0) ? oh(cur.idx) : 4'd0);
                    check_eq("kick_count", kick_cnt, cur.kick);
                    if (cur.kick != 0) check_eq("done_lat", cyc - fall_cyc, 1);
                    else               check_eq("reject_lat", cyc - acc_cyc, 2);
                    check_eq("beats", we_cnt[cur.idx], cur.beats);
                    other = we_cnt[0] + we_cnt[1] + we_cnt[2] + we_cnt[3] - we_cnt[cur.idx];
                    check_eq("stray_we", other, 0);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_ready"}, bus.req_ready, 4'd0);
        check_eq({tag, "_done"}, bus.done, 4'd0);
        check_eq({tag, "_err"}, bus.err, 4'd0);
        check_eq({tag, "_kick"}, bus.rd_kick, 1'b0);
        check_eq({tag, "_rd_num"}, bus.rd_num, 32'd0);
        check_eq({tag, "_rd_addr"}, bus.rd_addr, 32'd0);
        check_eq({tag, "_out_we"}, bus.out_we, 4'd0);
        check_eq({tag, "_owner"}, bus.owner, 2'd0);
        check_eq({tag, "_owner_valid"}, bus.owner_valid, 1'b0);
    endtask

    initial begin
        int t, g0;
        n_checks = 0; n_pass = 0; grants_seen = 0; short_by = 0;
        reset_n = 1'b0;
        bus.req_valid = 4'd0; bus.req_num = 128'd0; bus.req_addr = 128'd0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #2 reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single 100-beat job on requester 0.
        @(posedge clk); #2 submit(0, 32'd100, 32'h1000, 1, 0, 100);
        drain("drain_single", 500);

        // FIFO writes with no owner must be dropped.
        @(posedge clk); #2 bus.buf_we = 1'b1; bus.buf_dout = 32'hA5A5_5A5A;
        @(negedge clk);
        check_eq("idle_drop", bus.out_we, 4'd0);
        @(posedge clk); #2 bus.buf_we = 1'b0;

        // Zero-length job is rejected without a kick.
        @(posedge clk); #2 submit(2, 32'd0, 32'h2000, 0, 1, 0);
        drain("drain_zero", 50);

        // One beat beyond the limit is rejected.
        @(posedge clk); #2 submit(3, 32'd16321, 32'h4000, 0, 1, 0);
        drain("drain_over", 50);

        // All four at once, then requester 1 returns after its grant.
        g0 = grants_seen;
        @(posedge clk); #2;
        for (int i = 0; i < 4; i++) submit(i, 32'd8, 32'h100 * (i + 1), 1, 0, 8);
        t = 0;
        while (grants_seen < g0 + 2 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check_eq("regrant_wait", (grants_seen >= g0 + 2) ? 1 : 0, 1);
        @(posedge clk); #2 submit(1, 32'd8, 32'h900, 1, 0, 8);
        drain("drain_rr", 2000);

        // Exactly the limit is accepted and run.
        @(posedge clk); #2 submit(2, 32'd16320, 32'h8000, 1, 0, 16320);
        drain("drain_max", 20000);

        // Master delivers one beat short.
        short_by = 1;
        @(posedge clk); #2 submit(0, 32'd64, 32'hC000, 1, 1, 63);
        drain("drain_short", 500);
        short_by = 0;

        // Reset in the middle of a running job.
        @(posedge clk); #2 submit(1, 32'd200, 32'h3000, 1, 0, 200);
        t = 0;
        while (!bus.rd_busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_eq("busy_before_rst", bus.rd_busy, 1'b1);
        repeat (10) @(negedge clk);
        @(posedge clk); #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("midrst");
        exp_q.delete();
        @(posedge clk); #2 reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Pointer back at 0: requester 0 wins over requester 2.
        @(posedge clk); #2;
        submit(0, 32'd4, 32'h5000, 1, 0, 4);
        submit(2, 32'd4, 32'h6000, 1, 0, 4);
        drain("drain_post_rst", 500);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
